// File: rtl/sseg_pkg.sv
// Shared constants for the 7-segment scan decoder: segment codes, FSM states.
// Hex letters (SEG_A..SEG_F) are only decoded when SSEG_HEX_EN is defined.
package sseg_pkg;

   // Active-low gfedcba codes
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational segment pattern -> {hit, blank, val} lookup.
// SSEG_HEX_EN adds the A..F letter patterns; otherwise they are unknown.
module sseg_pattern_decode
   import sseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       hit,
   output logic       blank,
   output logic [3:0] val
);

   always_comb begin
      hit   = 1'b1;
      blank = 1'b0;
      val   = 4'h0;
      case (seg)
         SEG_0: val = 4'h0;
         SEG_1: val = 4'h1;
         SEG_2: val = 4'h2;
         SEG_3: val = 4'h3;
         SEG_4: val = 4'h4;
         SEG_5: val = 4'h5;
         SEG_6: val = 4'h6;
         SEG_7: val = 4'h7;
         SEG_8: val = 4'h8;
         SEG_9: val = 4'h9;
`ifdef SSEG_HEX_EN
         SEG_A: val = 4'hA;
         SEG_B: val = 4'hB;
         SEG_C: val = 4'hC;
         SEG_D: val = 4'hD;
         SEG_E: val = 4'hE;
         SEG_F: val = 4'hF;
`else
         SEG_A, SEG_B, SEG_C,
         SEG_D, SEG_E, SEG_F: hit = 1'b0;
`endif
         SEG_BLANK: begin
            hit   = 1'b0;
            blank = 1'b1;
         end
         default: hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Monitors a multiplexed 7-seg bus and rebuilds each digit after a settle window.
// Optional hex letter decode is enabled with SSEG_HEX_EN.
module sseg_scan_decoder
   import sseg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIGITS-1:0]     an,
   input  logic [6:0]            seg,
   input  logic                  err_clr,
   output logic [4*DIGITS-1:0]   digits_out,
   output logic [DIGITS-1:0]     digit_valid,
   output logic [DIGITS-1:0]     digit_blank,
   output logic                  frame_done,
   output logic                  err
);

   localparam int IW = idx_w(DIGITS);
   localparam int CW = idx_w(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [DIGITS-1:0]   s_an_q, s_an_d;
   logic [6:0]          s_seg_q, s_seg_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   state_e              state_q, state_d;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic [DIGITS-1:0]   valid_q, valid_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic [DIGITS-1:0]   mask_q, mask_d;
   logic                frame_q, frame_d;
   logic                err_q, err_d;

   logic          dec_hit, dec_blank;
   logic [3:0]    dec_val;
   logic [IW-1:0] idx;
   logic          all_high, one_low, capture, new_err;

   sseg_pattern_decode u_dec (
      .seg   (s_seg_q),
      .hit   (dec_hit),
      .blank (dec_blank),
      .val   (dec_val)
   );

   assign all_high = &s_an_q;
   assign one_low  = $onehot(~s_an_q);

   always_comb begin
      idx = '0;
      for (int i = 0; i < DIGITS; i++)
         if (!s_an_q[i]) idx = IW'(i);
   end

   always_comb begin
      s_an_d  = an;
      s_seg_d = seg;
      if ((an == s_an_q) && (seg == s_seg_q))
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      else
         cnt_d = '0;

      // cnt_q==0 marks a freshly changed sample: restart the dwell
      state_d = state_q;
      capture = 1'b0;
      if (all_high) begin
         state_d = ST_IDLE;
      end else if (cnt_q == '0) begin
         state_d = ST_SETTLE;
      end else begin
         unique case (state_q)
            ST_IDLE:   state_d = ST_SETTLE;
            ST_SETTLE: begin
               if (cnt_q == CNT_MAX) begin
                  state_d = ST_HOLD;
                  capture = 1'b1;
               end
            end
            ST_HOLD:   state_d = ST_HOLD;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      digits_d = digits_q;
      valid_d  = valid_q;
      blank_d  = blank_q;
      mask_d   = mask_q;
      frame_d  = 1'b0;
      new_err  = 1'b0;
      if (capture) begin
         if (!one_low) begin
            new_err = 1'b1;
         end else if (dec_blank) begin
            valid_d[idx] = 1'b1;
            blank_d[idx] = 1'b1;
            mask_d[idx]  = 1'b1;
         end else if (dec_hit) begin
            digits_d[4*int'(idx) +: 4] = dec_val;
            valid_d[idx] = 1'b1;
            blank_d[idx] = 1'b0;
            mask_d[idx]  = 1'b1;
         end else begin
            new_err = 1'b1;
         end
      end
      if (&mask_d) begin
         frame_d = 1'b1;
         mask_d  = '0;
      end
      // A fresh error outranks a simultaneous clear
      err_d = new_err ? 1'b1 : (err_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_an_q   <= '1;
         s_seg_q  <= SEG_BLANK;
         cnt_q    <= '0;
         state_q  <= ST_IDLE;
         digits_q <= '0;
         valid_q  <= '0;
         blank_q  <= '0;
         mask_q   <= '0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         s_an_q   <= s_an_d;
         s_seg_q  <= s_seg_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         digits_q <= digits_d;
         valid_q  <= valid_d;
         blank_q  <= blank_d;
         mask_q   <= mask_d;
         frame_q  <= frame_d;
         err_q    <= err_d;
      end
   end

   assign digits_out  = digits_q;
   assign digit_valid = valid_q;
   assign digit_blank = blank_q;
   assign frame_done  = frame_q;
   assign err         = err_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed self-checking bench for sseg_scan_decoder (default 4 digits, 16-cycle settle).
// Build with +define+SSEG_HEX_EN to check the hex letter decode instead of the error path.
module tb_sseg_scan_decoder;
   import sseg_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  an = 4'hF;
   logic [6:0]  seg = SEG_BLANK;
   logic        err_clr = 1'b0;
   logic [15:0] digits_out;
   logic [3:0]  digit_valid;
   logic [3:0]  digit_blank;
   logic        frame_done;
   logic        err;

   int total = 0;
   int bad = 0;
   int frame_cnt = 0;

   sseg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .seg         (seg),
      .err_clr     (err_clr),
      .digits_out  (digits_out),
      .digit_valid (digit_valid),
      .digit_blank (digit_blank),
      .frame_done  (frame_done),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (frame_done === 1'b1) frame_cnt <= frame_cnt + 1;

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      @(negedge clk);
      an  = a;
      seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      an  = 4'b1110;
      seg = SEG_7;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({digits_out, digit_valid, digit_blank, frame_done, err} !== 26'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h %h %h %b %b, want all 0",
                  digits_out, digit_valid, digit_blank, frame_done, err);
      end
      @(negedge clk);
      rst = 1'b0;
      an  = 4'hF;
      seg = SEG_BLANK;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (digit_valid !== 4'h0 || digits_out !== 16'h0) begin
         bad++;
         $display("FAIL reset_no_capture: valid=%h digits=%h, want 0 0",
                  digit_valid, digits_out);
      end
   endtask

   task automatic test_scan;
      int first;
      int f0;
      f0 = frame_cnt;
      first = 0;
      drive(4'b1110, SEG_3, 0);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (first == 0 && digit_valid[0] === 1'b1) first = k;
      end
      total++;
      if (first != 17) begin
         bad++;
         $display("FAIL scan_latency: got %0d clocks, want 17", first);
      end
      drive(4'b1101, SEG_0, 20);
      drive(4'b1011, SEG_9, 20);
      drive(4'b0111, SEG_5, 20);
      drive(4'b1111, SEG_BLANK, 3);
      total++;
      if (digits_out !== 16'h5903) begin
         bad++;
         $display("FAIL scan_digits: got %h, want 5903", digits_out);
      end
      total++;
      if (digit_valid !== 4'hF) begin
         bad++;
         $display("FAIL scan_valid: got %h, want f", digit_valid);
      end
      total++;
      if (frame_cnt - f0 != 1) begin
         bad++;
         $display("FAIL scan_frame: got %0d pulses, want 1", frame_cnt - f0);
      end
   endtask

   task automatic test_short_dwell;
      int f0;
      f0 = frame_cnt;
      drive(4'b1011, SEG_8, 10);
      drive(4'b1111, SEG_BLANK, 20);
      total++;
      if (digits_out !== 16'h5903) begin
         bad++;
         $display("FAIL short_dwell_digits: got %h, want 5903", digits_out);
      end
      total++;
      if (frame_cnt != f0) begin
         bad++;
         $display("FAIL short_dwell_frame: got %0d pulses, want 0", frame_cnt - f0);
      end
   endtask

   task automatic test_blank;
      drive(4'b1101, SEG_BLANK, 20);
      drive(4'b1111, SEG_BLANK, 2);
      total++;
      if (digit_blank !== 4'b0010) begin
         bad++;
         $display("FAIL blank_flag: got %b, want 0010", digit_blank);
      end
      total++;
      if (digits_out !== 16'h5903 || digit_valid !== 4'hF) begin
         bad++;
         $display("FAIL blank_keep: got %h/%h, want 5903/f", digits_out, digit_valid);
      end
   endtask

   task automatic test_hex;
      drive(4'b1110, SEG_A, 20);
      drive(4'b1111, SEG_BLANK, 2);
`ifdef SSEG_HEX_EN
      total++;
      if (digits_out !== 16'h590A || err !== 1'b0) begin
         bad++;
         $display("FAIL hex_decode: got %h err=%b, want 590a err=0", digits_out, err);
      end
`else
      total++;
      if (digits_out !== 16'h5903 || err !== 1'b1) begin
         bad++;
         $display("FAIL hex_unknown: got %h err=%b, want 5903 err=1", digits_out, err);
      end
`endif
   endtask

   task automatic test_multi_anode;
      logic [15:0] d0;
      d0 = digits_out;
      @(negedge clk);
      an = 4'hF;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL clr_start: got err=%b, want 0", err);
      end
      drive(4'b1100, SEG_1, 20);
      total++;
      if (err !== 1'b1 || digits_out !== d0) begin
         bad++;
         $display("FAIL multi_err: got err=%b digits=%h, want 1 %h", err, digits_out, d0);
      end
      drive(4'b1111, SEG_BLANK, 2);
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL clr_alone: got err=%b, want 0", err);
      end
      // Capture edge is the 17th posedge after the change; clear rides on it
      drive(4'b1100, SEG_2, 16);
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL multi_early: got err=%b, want 0", err);
      end
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL set_wins: got err=%b, want 1", err);
      end
      drive(4'b1111, SEG_BLANK, 3);
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL clr_later: got err=%b, want 0", err);
      end
   endtask

   initial begin
      test_reset;
      test_scan;
      test_short_dwell;
      test_blank;
      test_hex;
      test_multi_anode;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
